// File: rtl/automata_row_sequencer_pkg.sv
// Shared types and widths for the automaton row sequencer.
package automata_row_sequencer_pkg;
   localparam int CELL_W = 20;
   localparam int WIN_W  = 22;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_FETCH = 3'd2,
      S_SHIFT = 3'd3,
      S_HOLD  = 3'd4,
      S_FLUSH = 3'd5,
      S_DONE  = 3'd6
   } state_e;
endpackage

// File: rtl/automata_row_sequencer_row_addr_gen.sv
// Word counter and cell-memory address generator for one automaton row.
// pre selects the last word (toroidal pre-fetch); k == WORDS_PER_ROW wraps the word back to 0.
module row_addr_gen #(
   parameter int WORDS_PER_ROW = 32,
   parameter int ADDR_W        = 10,
   parameter int K_W           = $clog2(WORDS_PER_ROW + 1)
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              load,
   input  logic              inc,
   input  logic              pre,
   input  logic [ADDR_W-1:0] base,
   output logic [K_W-1:0]    k,
   output logic              k_end,
   output logic [ADDR_W-1:0] addr
);
   logic [ADDR_W-1:0] base_q;
   logic [K_W-1:0]    word;

   always_ff @(posedge clk) begin
      if (clear) begin
         base_q <= '0;
         k      <= '0;
      end else if (load) begin
         base_q <= base;
         k      <= '0;
      end else if (inc) begin
         k <= k + K_W'(1);
      end
   end

   assign k_end = (k == K_W'(WORDS_PER_ROW));

   always_comb begin
      word = k;
      if (pre)
         word = K_W'(WORDS_PER_ROW - 1);
      else if (k_end)
         word = '0;
   end

   // Address arithmetic is allowed to wrap modulo 2^ADDR_W.
   assign addr = base_q + ADDR_W'(word);
endmodule

// File: rtl/automata_row_sequencer.sv
// Sequences one automaton row through an external shift buffer, presenting one 22-bit window per word.
// Build option ROW_WRAP_EN: toroidal row (last word pre-loaded, word 0 re-read as flush word).
//
// state   | meaning
// IDLE    | waiting for start
// CLR     | clearing the shift buffer
// FETCH   | reading a cell word from memory
// SHIFT   | shifting the fetched word into the buffer
// HOLD    | window valid, waiting for win_ready
// FLUSH   | shifting the word beyond the row end
// DONE    | one-cycle completion pulse
module automata_row_sequencer
   import automata_row_sequencer_pkg::*;
#(
   parameter int WORDS_PER_ROW = 32,
   parameter int ADDR_W        = 10
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              start,
   input  logic [ADDR_W-1:0] row_base,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [CELL_W-1:0] rd_data,
   output logic              buf_clear,
   output logic              buf_shift,
   output logic [CELL_W-1:0] buf_din,
   output logic              win_valid,
   input  logic              win_ready,
   output logic [ADDR_W-1:0] win_index,
   output logic              busy,
   output logic              done
);
   localparam int K_W = $clog2(WORDS_PER_ROW + 1);

`ifdef ROW_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   state_e            state;
   logic [K_W-1:0]    k;
   logic              k_end;
   logic              k_lt;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] idx_q;
   logic              pre_q;
   logic              last_q;
   logic [CELL_W-1:0] flush_word;

   row_addr_gen #(
      .WORDS_PER_ROW (WORDS_PER_ROW),
      .ADDR_W        (ADDR_W),
      .K_W           (K_W)
   ) u_addr_gen (
      .clk   (clk),
      .clear (clear),
      .load  (state == S_IDLE && start),
      .inc   (state == S_SHIFT && !pre_q),
      .pre   (pre_q),
      .base  (row_base),
      .k     (k),
      .k_end (k_end),
      .addr  (addr)
   );

   assign k_lt = (k < K_W'(WORDS_PER_ROW));

   always_ff @(posedge clk) begin
      if (clear) begin
         state  <= S_IDLE;
         idx_q  <= '0;
         pre_q  <= 1'b0;
         last_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               last_q <= 1'b0;
               if (start)
                  state <= S_CLR;
            end
            S_CLR: begin
               pre_q <= WRAP_EN;
               state <= S_FETCH;
            end
            // In toroidal mode the fetch at k == WORDS_PER_ROW is the word-0 flush read.
            S_FETCH: state <= (WRAP_EN && k_end) ? S_FLUSH : S_SHIFT;
            S_SHIFT: begin
               if (pre_q) begin
                  pre_q <= 1'b0;
                  state <= S_FETCH;
               end else if (k == '0) begin
                  state <= S_FETCH;
               end else begin
                  idx_q <= ADDR_W'(k - K_W'(1));
                  state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (win_ready) begin
                  if (last_q)
                     state <= S_DONE;
                  else if (k_lt || WRAP_EN)
                     state <= S_FETCH;
                  else
                     state <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               last_q <= 1'b1;
               idx_q  <= ADDR_W'(WORDS_PER_ROW - 1);
               state  <= S_HOLD;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef ROW_WRAP_EN
   assign flush_word = rd_data;
`else
   assign flush_word = '0;
`endif

   assign rd_en     = (state == S_FETCH);
   assign rd_addr   = rd_en ? addr : '0;
   assign buf_clear = (state == S_CLR);
   assign buf_shift = (state == S_SHIFT) || (state == S_FLUSH);
   assign buf_din   = (state == S_SHIFT) ? rd_data :
                      (state == S_FLUSH) ? flush_word : '0;
   assign win_valid = (state == S_HOLD);
   assign win_index = win_valid ? idx_q : '0;
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
endmodule

// File: tb/tb_automata_row_sequencer.sv
// Self-checking bench for automata_row_sequencer; honours ROW_WRAP_EN when defined.
module tb_automata_row_sequencer;
   localparam int W  = 4;
   localparam int AW = 10;
`ifdef ROW_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          clear;
   logic          start;
   logic [AW-1:0] row_base;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [19:0]   rd_data;
   logic          buf_clear;
   logic          buf_shift;
   logic [19:0]   buf_din;
   logic          win_valid;
   logic          win_ready;
   logic [AW-1:0] win_index;
   logic          busy;
   logic          done;

   logic [19:0] mem [0:1023];
   int checks = 0;
   int errors = 0;

   automata_row_sequencer #(.WORDS_PER_ROW(W), .ADDR_W(AW)) dut (
      .clk       (clk),
      .clear     (clear),
      .start     (start),
      .row_base  (row_base),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .buf_clear (buf_clear),
      .buf_shift (buf_shift),
      .buf_din   (buf_din),
      .win_valid (win_valid),
      .win_ready (win_ready),
      .win_index (win_index),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // One-cycle read latency; junk when not reading.
   always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 20'($urandom);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_ctl"}, {26'd0, rd_en, buf_clear, buf_shift, win_valid, busy, done}, 32'd0);
      chk({tag, "_addr"}, {12'd0, rd_addr, win_index}, 32'd0);
      chk({tag, "_din"}, {12'd0, buf_din}, 32'd0);
   endtask

   function automatic logic [19:0] word_at(input logic [AW-1:0] base, input int j);
      logic [AW-1:0] a;
      a = base + AW'(j);
      return mem[a];
   endfunction

   // Neighbourhood of word i: right-most cell of word i-1, word i, left-most cell of word i+1.
   function automatic logic [21:0] exp_win(input logic [AW-1:0] base, input int i);
      logic [19:0] w, wl, wr;
      logic l, r;
      w  = word_at(base, i);
      wl = word_at(base, (i == 0) ? W - 1 : i - 1);
      wr = word_at(base, (i == W - 1) ? 0 : i + 1);
      l  = (i == 0 && !WRAP) ? 1'b0 : wl[0];
      r  = (i == W - 1 && !WRAP) ? 1'b0 : wr[19];
      return {l, w, r};
   endfunction

   task automatic run_row(input logic [AW-1:0] base, input int stall_at, input int clear_at,
                          input bit spam, input bit rnd);
      logic [40:0]   bufm;
      logic [AW-1:0] addrs[$];
      logic [AW-1:0] exp_a[$];
      logic [19:0]   last_din;
      logic [19:0]   exp_flush;
      int win_cnt, cyc, stall_cnt, prev_cyc, seen_idx;
      bit expect_done, done_seen, aborted, stall_active;
      bufm = '0; last_din = '1; win_cnt = 0; cyc = 0; stall_cnt = 0; prev_cyc = 0; seen_idx = -1;
      expect_done = 0; done_seen = 0; aborted = 0; stall_active = 0;

      @(negedge clk);
      row_base = base;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      row_base = AW'($urandom);

      while (!done_seen && !aborted && cyc < 400) begin
         if (stall_active) chk("stall_hold", {29'd0, win_valid, rd_en, buf_shift}, 32'd4);
         stall_active = 0;
         chk("shift_while_valid", {31'd0, buf_shift & win_valid}, 32'd0);
         chk("done", {31'd0, done}, {31'd0, expect_done});
         if (expect_done) done_seen = 1;
         if (rd_en) addrs.push_back(rd_addr);
         win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (win_valid) begin
            if (seen_idx != win_cnt) begin
               if (!rnd && stall_at < 0 && win_cnt >= 1 && win_cnt <= W - 2)
                  chk("window_period", cyc - prev_cyc, 32'd3);
               prev_cyc = cyc;
               seen_idx = win_cnt;
            end
            chk("win_index", {22'd0, win_index}, win_cnt);
            chk("window", {10'd0, bufm[40:19]}, {10'd0, exp_win(base, win_cnt)});
            if (win_cnt == stall_at && stall_cnt < 10) begin
               win_ready    = 1'b0;
               stall_cnt++;
               stall_active = 1;
            end
            if (win_cnt == clear_at) begin
               win_ready = 1'b0;
               clear     = 1'b1;
               aborted   = 1;
            end else if (win_ready) begin
               win_cnt++;
               if (win_cnt == W) expect_done = 1;
            end
         end
         if (buf_clear) begin
            bufm = '0;
         end else if (buf_shift) begin
            bufm     = {bufm[20:0], buf_din};
            last_din = buf_din;
         end
         start = spam && (cyc % 7 == 3);
         if (start) row_base = AW'($urandom);
         @(negedge clk);
         cyc++;
      end
      start     = 1'b0;
      win_ready = 1'b0;

      if (aborted) begin
         clear = 1'b0;
         check_idle("after_clear");
         repeat (8) begin
            @(negedge clk);
            chk("no_done_after_abort", {30'd0, busy, done}, 32'd0);
         end
      end else begin
         chk("row_completed", {31'd0, done_seen}, 32'd1);
         chk("window_count", win_cnt, W);
         if (WRAP) exp_a.push_back(base + AW'(W - 1));
         for (int j = 0; j < W; j++) exp_a.push_back(base + AW'(j));
         if (WRAP) exp_a.push_back(base);
         chk("fetch_count", addrs.size(), exp_a.size());
         for (int j = 0; j < exp_a.size() && j < addrs.size(); j++)
            chk("rd_addr", {22'd0, addrs[j]}, {22'd0, exp_a[j]});
         exp_flush = WRAP ? word_at(base, 0) : 20'd0;
         chk("flush_word", {12'd0, last_din}, {12'd0, exp_flush});
         check_idle("after_done");
      end
   endtask

   initial begin
      clear     = 1'b1;
      start     = 1'b0;
      row_base  = '0;
      win_ready = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 20'($urandom);
      repeat (3) @(negedge clk);
      check_idle("reset");

      // start coinciding with clear must be dropped
      start    = 1'b1;
      row_base = 10'h155;
      @(negedge clk);
      start = 1'b0;
      clear = 1'b0;
      check_idle("clear_start");
      @(negedge clk);
      check_idle("clear_start_later");

      run_row(10'h3FE, -1, -1, 1'b0, 1'b0);
      run_row(AW'($urandom), 1, -1, 1'b0, 1'b0);
      run_row(AW'($urandom), -1, 2, 1'b0, 1'b0);
      run_row(AW'($urandom), -1, -1, 1'b0, 1'b0);
      run_row(AW'($urandom), -1, -1, 1'b1, 1'b0);

      for (int i = 0; i < 1024; i++) mem[i] = 20'hFFFFF;
      run_row(AW'($urandom), -1, -1, 1'b0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 1024; i++) mem[i] = 20'($urandom);
         run_row(AW'($urandom), int'($urandom_range(0, W)), -1, 1'b1, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/automata_row_sequencer.md
AUTOMATA_ROW_SEQUENCER -- requirements
Module: automata_row_sequencer

Interface
REQ-001 SHALL have parameter WORDS_PER_ROW, default 32, number of 20-bit cell words per automaton row (legal range 2..1023).
REQ-002 SHALL have parameter ADDR_W, default 10, cell-memory word address width.
REQ-003 SHALL have these ports: clk  in  1  sole clock, all logic on rising edge.
REQ-004 clear  in  1  reset; synchronous, active-high.
REQ-005 start  in  1  begin sequencing one row; sampled only in IDLE.
REQ-006 row_base  in  ADDR_W  address of word 0 of the row; latched on accepted start.
REQ-007 rd_en  out  1  cell-memory read strobe.
REQ-008 rd_addr  out  ADDR_W  cell-memory read address.
REQ-009 rd_data  in  20  cell-memory data, valid exactly one cycle after rd_en.
REQ-010 buf_clear  out  1  drives shift-buffer clear.
REQ-011 buf_shift  out  1  drives shift-buffer shift_enable.
REQ-012 buf_din  out  20  drives shift-buffer din.
REQ-013 win_valid  out  1  shift-buffer 22-bit window is a complete neighbourhood.
REQ-014 win_ready  in  1  rule engine has consumed the window.
REQ-015 win_index  out  ADDR_W  index (0..WORDS_PER_ROW-1) of the word centred in the window.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle pulse after the last window is consumed.

Function
REQ-018 States SHALL be IDLE, CLR, FETCH, SHIFT, HOLD, FLUSH, DONE.
REQ-019 IDLE: start=1 SHALL latch row_base, zero word counter k, go to CLR; start while busy SHALL be ignored.
REQ-020 CLR: buf_clear=1 for exactly one cycle, then FETCH.
REQ-021 FETCH: rd_en=1, rd_addr=row_base+k (mod 2^ADDR_W), then SHIFT.
REQ-022 SHIFT: buf_shift=1, buf_din=rd_data, k increments; if k was 0 go to FETCH, else go to HOLD with win_index=k-1.
REQ-023 HOLD: win_valid=1, buf_shift=0; stay until win_ready=1; then FETCH if k<WORDS_PER_ROW, else FLUSH.
REQ-024 FLUSH: one cycle buf_shift=1 with flush word (REQ-033/034), then HOLD with win_index=WORDS_PER_ROW-1; after that window is consumed go to DONE.
REQ-025 DONE: done=1 for one cycle, then IDLE.
REQ-026 Exactly WORDS_PER_ROW windows SHALL be presented per start, indices strictly 0,1,..,WORDS_PER_ROW-1.
REQ-027 buf_shift SHALL never be high while win_valid is high (window stable until consumed).
REQ-028 win_ready outside HOLD SHALL be ignored; win_ready held high SHALL give one window per 3 cycles (FETCH, SHIFT, HOLD).
REQ-029 Address arithmetic SHALL wrap modulo 2^ADDR_W without error.
REQ-030 rd_en, buf_clear, buf_shift, win_valid, done SHALL be mutually consistent with state only (Moore outputs, registered or decoded from state).

Reset
REQ-031 clear=1 on any edge SHALL force IDLE, k=0 and all outputs 0, including mid-row; no done pulse SHALL follow an aborted row.
REQ-032 A start asserted in the same cycle as clear SHALL be ignored.

Configuration
REQ-033 With ROW_WRAP_EN undefined: FLUSH word SHALL be 20'd0 (dead cells beyond row end); CLR leaves buffer zero (dead cells before word 0).
REQ-034 With ROW_WRAP_EN defined: toroidal row; CLR SHALL be followed by an extra fetch/shift of word WORDS_PER_ROW-1 before word 0, and FLUSH SHALL re-read word 0 (FETCH then shift rd_data) instead of shifting zero; window count and indices unchanged.

Structure
REQ-035 A shared package SHALL hold the state enum type, CELL_W=20, WIN_W=22.
REQ-036 Word counter/address generator SHALL be one sub-module, row_addr_gen (load, increment, wrap).
REQ-037 The shift buffer SHALL be instantiated externally; this block only drives it.

Verification
REQ-038 WORDS_PER_ROW=4, row_base=0x3FE, win_ready=1: rd_addr sequence 0x3FE,0x3FF,0x000,0x001; indices 0..3; done 1 cycle after 4th window.
REQ-039 win_ready=0 for 10 cycles during HOLD of index 1: win_valid held, buf_shift=0, no rd_en until release.
REQ-040 clear pulsed during HOLD of index 2: next cycle IDLE, all outputs 0, no done; new start runs full row.
REQ-041 start pulsed while busy: ignored, row_base not re-latched, index sequence unchanged.
REQ-042 Memory words 0xFFFFF everywhere, no ROW_WRAP_EN: last flush shifts 0x00000; with ROW_WRAP_EN: first data read is word 3, flush re-reads word 0.
REQ-043 Scoreboard: reference 41-bit buffer model fed from buf_* checks every presented window equals expected neighbourhood.
